buffer_scan_ctrl: RTL and testbench
===================================

BUFFER_SCAN_CTRL -- requirements
Module: buffer_scan_ctrl

Interface
REQ-001 Parameter IMG_W, 16, image width in pixels; the block SHALL support any value from 3 to 255.
REQ-002 Parameter IMG_H, 16, image height in pixels; the block SHALL support any value from 3 to 255.
REQ-003 Port clk  in  1  single system clock; all state SHALL update on its rising edge.
REQ-004 Port n_rst  in  1  reset, asynchronous, active-low.
REQ-005 Port start  in  1  scan request, sampled only in IDLE.
REQ-006 Port busy  out  1  high in FETCH, EMIT and DONE.
REQ-007 Port done  out  1  one-cycle pulse after the last window is accepted.
REQ-008 Port rd_req  out  1  pixel-triplet fetch request to the pixel source.
REQ-009 Port rd_x  out  8  fetch start column.
REQ-010 Port rd_y  out  8  fetch start row.
REQ-011 Port rd_orient  out  1  fetch shape: 0 = vertical triplet (x,y)..(x,y+2); 1 = horizontal triplet (x,y)..(x+2,y).
REQ-012 Port rd_ack  in  1  triplet valid on the 3x3 buffer input this cycle.
REQ-013 Port shift_enable  out  1  drives the 3x3 buffer shift_enable.
REQ-014 Port shift_direction  out  2  drives the 3x3 buffer: 00 hold, 01 move right (new right column), 10 move left (new left column), 11 move down (new bottom row).
REQ-015 Port win_valid  out  1  3x3 buffer contents form a valid window.
REQ-016 Port win_ready  in  1  downstream accepts the window.
REQ-017 Port win_x  out  8  top-left column of the current window.
REQ-018 Port win_y  out  8  top-left row of the current window.

Function
REQ-019 The FSM SHALL have the states IDLE, FETCH, EMIT and DONE.
REQ-020 IDLE -> FETCH on start=1; wx, wy and the fill count SHALL be cleared and the direction set to 01.
REQ-021 In FETCH, rd_req SHALL be 1, and rd_x, rd_y, rd_orient and shift_direction SHALL stay stable until rd_ack.
REQ-022 shift_enable SHALL equal (state==FETCH) & rd_ack (combinational), giving exactly one buffer shift per triplet.
REQ-023 rd_ack outside FETCH SHALL be ignored.
REQ-024 Fill: the first three fetches of a scan SHALL be vertical triplets at columns 0, 1, 2 of row 0 with direction 01; FETCH SHALL repeat until all three are acked.
REQ-025 After the final shift of a step (fill or single fetch), the next state SHALL be EMIT.
REQ-026 win_valid SHALL be 1 only in EMIT, aligned with the updated buffer contents.
REQ-027 EMIT SHALL hold, with no shift and no fetch, while win_ready=0.
REQ-028 On the EMIT handshake (win_valid & win_ready), with direction right: if wx<IMG_W-3, fetch a vertical triplet at (wx+3, wy) with direction 01, then wx++.
REQ-029 On the EMIT handshake, with direction left: if wx>0, fetch a vertical triplet at (wx-1, wy) with direction 10, then wx--.
REQ-030 At a row end (wx==IMG_W-3 moving right, or wx==0 moving left) with wy<IMG_H-3: fetch a horizontal triplet at (wx, wy+3) with direction 11, then wy++, and reverse the horizontal direction (serpentine).
REQ-031 At a row end with wy==IMG_H-3, the next state SHALL be DONE.
REQ-032 In DONE, done SHALL be 1 for one cycle, followed by IDLE.
REQ-033 start SHALL be ignored while busy=1.
REQ-034 Window count per scan SHALL be (IMG_W-2)*(IMG_H-2).
REQ-035 win_x and win_y SHALL equal wx and wy.

Reset
REQ-036 n_rst=0 SHALL immediately force IDLE.
REQ-037 During reset, all outputs SHALL be 0, including shift_direction=00 and rd_x=rd_y=0.
REQ-038 The internal counters SHALL clear on reset.
REQ-039 A reset mid-scan SHALL abandon the scan with no done pulse.

Verification
REQ-040 IMG_W=IMG_H=4, start, rd_ack every FETCH cycle, win_ready=1 -> fetches (0,0,v,01), (1,0,v,01), (2,0,v,01); window (0,0); fetch (3,0,v,01); window (1,0); fetch (1,3,h,11); window (1,1); fetch (0,1,v,10); window (0,1); then a single done pulse.
REQ-041 rd_ack delayed 3 cycles per fetch -> rd_req and rd_x/rd_y/rd_orient held constant, shift_enable=0 until the ack cycle, and the window sequence is unchanged.
REQ-042 win_ready=0 for 5 cycles in the first EMIT -> win_valid held with win_x=0, win_y=0, no rd_req and no shift_enable during the stall.
REQ-043 start pulsed mid-scan and rd_ack pulsed in EMIT -> no effect, and exactly 4 windows are emitted.
REQ-044 n_rst asserted during the 2nd window, then a new start -> outputs 0 at once, no done pulse, and the new scan restarts from fill at (0,0).
REQ-045 IMG_W=5, IMG_H=3 -> windows (0,0), (1,0), (2,0), no direction-11 fetch, then done.

Source files
------------

// File: rtl/buffer_scan_ctrl_if.sv
// Handshake bundle between the scan controller, the pixel source, the 3x3 buffer and the window consumer.
// The master side is the controller; the slave side is its environment.
interface buffer_scan_ctrl_if;
    logic       start;
    logic       busy;
    logic       done;
    logic       rd_req;
    logic [7:0] rd_x;
    logic [7:0] rd_y;
    logic       rd_orient;
    logic       rd_ack;
    logic       shift_enable;
    logic [1:0] shift_direction;
    logic       win_valid;
    logic       win_ready;
    logic [7:0] win_x;
    logic [7:0] win_y;

    modport master (
        input  start, rd_ack, win_ready,
        output busy, done, rd_req, rd_x, rd_y, rd_orient,
               shift_enable, shift_direction, win_valid, win_x, win_y
    );

    modport slave (
        output start, rd_ack, win_ready,
        input  busy, done, rd_req, rd_x, rd_y, rd_orient,
               shift_enable, shift_direction, win_valid, win_x, win_y
    );
endinterface

// File: rtl/buffer_scan_ctrl.sv
// Serpentine 3x3 window scan controller: fills the buffer with three column fetches, then one triplet per window.
// Each window waits in EMIT until win_ready; each fetch holds its request stable until rd_ack.
module buffer_scan_ctrl #(
    parameter int IMG_W = 16,
    parameter int IMG_H = 16
) (
    input  logic                clk,
    input  logic                n_rst,
    buffer_scan_ctrl_if.master  bus
);

    typedef enum logic [1:0] {IDLE, FETCH, EMIT, DONE} state_t;

    localparam logic [7:0] X_LAST    = 8'(IMG_W - 3);
    localparam logic [7:0] Y_LAST    = 8'(IMG_H - 3);
    localparam logic [1:0] DIR_HOLD  = 2'b00;
    localparam logic [1:0] DIR_RIGHT = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_DOWN  = 2'b11;

    state_t     state, state_nxt;
    logic [7:0] wx, wy;
    logic [7:0] fx, fy;
    logic       f_orient;
    logic [1:0] f_dir;
    logic [1:0] fill_cnt;
    logic       move_left;
    logic       step_right, step_left, step_down;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        step_right = !move_left && (wx < X_LAST);
        step_left  = move_left && (wx != 8'd0);
        step_down  = wy < Y_LAST;

        state_nxt = state;
        case (state)
            IDLE:  if (bus.start) state_nxt = FETCH;
            // Fill stays in FETCH until its third column lands
            FETCH: if (bus.rd_ack && (fill_cnt >= 2'd2)) state_nxt = EMIT;
            EMIT:  if (bus.win_ready)
                       state_nxt = (step_right || step_left || step_down) ? FETCH : DONE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        bus.busy            = (state != IDLE);
        bus.done            = (state == DONE);
        bus.rd_req          = (state == FETCH);
        bus.rd_x            = fx;
        bus.rd_y            = fy;
        bus.rd_orient       = f_orient;
        bus.shift_enable    = (state == FETCH) && bus.rd_ack;
        bus.shift_direction = (state == FETCH) ? f_dir : DIR_HOLD;
        bus.win_valid       = (state == EMIT);
        bus.win_x           = wx;
        bus.win_y           = wy;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wx        <= 8'd0;
            wy        <= 8'd0;
            fx        <= 8'd0;
            fy        <= 8'd0;
            f_orient  <= 1'b0;
            f_dir     <= DIR_HOLD;
            fill_cnt  <= 2'd0;
            move_left <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    wx        <= 8'd0;
                    wy        <= 8'd0;
                    fx        <= 8'd0;
                    fy        <= 8'd0;
                    f_orient  <= 1'b0;
                    f_dir     <= DIR_RIGHT;
                    fill_cnt  <= 2'd0;
                    move_left <= 1'b0;
                end
                FETCH: if (bus.rd_ack) begin
                    if (fill_cnt != 2'd3) begin
                        fill_cnt <= fill_cnt + 2'd1;
                        fx       <= fx + 8'd1;
                    end else begin
                        // Window origin follows the buffer once the new triplet is in
                        case (f_dir)
                            DIR_RIGHT: wx <= wx + 8'd1;
                            DIR_LEFT:  wx <= wx - 8'd1;
                            DIR_DOWN: begin
                                wy        <= wy + 8'd1;
                                move_left <= !move_left;
                            end
                            default: ;
                        endcase
                    end
                end
                EMIT: if (bus.win_ready) begin
                    if (step_right) begin
                        fx       <= wx + 8'd3;
                        fy       <= wy;
                        f_orient <= 1'b0;
                        f_dir    <= DIR_RIGHT;
                    end else if (step_left) begin
                        fx       <= wx - 8'd1;
                        fy       <= wy;
                        f_orient <= 1'b0;
                        f_dir    <= DIR_LEFT;
                    end else if (step_down) begin
                        fx       <= wx;
                        fy       <= wy + 8'd3;
                        f_orient <= 1'b1;
                        f_dir    <= DIR_DOWN;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_buffer_scan_ctrl.sv
// Directed bench for buffer_scan_ctrl: 4x4 scans under ack delay, window stall, stray inputs and reset,
// plus a 5x3 scan; fetch and window streams are compared against hand-derived tables.
module tb_buffer_scan_ctrl;

    logic tb_clk = 1'b0;
    logic tb_rst_n = 1'b0;
    always #5 tb_clk = ~tb_clk;

    buffer_scan_ctrl_if b4();
    buffer_scan_ctrl_if b53();

    buffer_scan_ctrl #(.IMG_W(4), .IMG_H(4)) dut4 (.clk(tb_clk), .n_rst(tb_rst_n), .bus(b4));
    buffer_scan_ctrl #(.IMG_W(5), .IMG_H(3)) dut53 (.clk(tb_clk), .n_rst(tb_rst_n), .bus(b53));

    // fetch entry = {x, y, orient, direction}; window entry = {x, y}
    localparam logic [18:0] EXP_F4 [6] = '{
        {8'd0, 8'd0, 1'b0, 2'b01}, {8'd1, 8'd0, 1'b0, 2'b01}, {8'd2, 8'd0, 1'b0, 2'b01},
        {8'd3, 8'd0, 1'b0, 2'b01}, {8'd1, 8'd3, 1'b1, 2'b11}, {8'd0, 8'd1, 1'b0, 2'b10}};
    localparam logic [15:0] EXP_W4 [4]  = '{16'h0000, 16'h0100, 16'h0101, 16'h0001};
    localparam logic [15:0] EXP_W53 [3] = '{16'h0000, 16'h0100, 16'h0200};

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
        end
    endtask

    int  ack_delay = 0;
    int  stall_cfg = 0;
    bit  stray     = 1'b0;

    int  w4 = 0, stall_left = 0, n_stall = 0, n_shift = 0, n_done = 0;
    int  hold_viol = 0, se_viol = 0;
    bit  prev_busy = 1'b0, pend = 1'b0, stalling = 1'b0;
    logic [18:0] pend_val = '0, cur = '0;
    logic [18:0] fq [$];
    logic [15:0] wq [$];

    // 4x4 environment: decides inputs at the falling edge, then logs what the next rising edge will see
    always begin
        @(negedge tb_clk);
        if (b4.rd_req) begin
            if (w4 >= ack_delay) begin b4.rd_ack = 1'b1; w4 = 0; end
            else begin b4.rd_ack = 1'b0; w4++; end
        end else begin
            w4 = 0;
            b4.rd_ack = stray && b4.win_valid;
        end
        if (!prev_busy && b4.busy) stall_left = stall_cfg;
        prev_busy = b4.busy;
        stalling = b4.win_valid && (stall_left > 0);
        b4.win_ready = !stalling;
        #1;
        if (stalling) begin
            stall_left--;
            n_stall++;
            check_eq("stall_win_x", b4.win_x, 0);
            check_eq("stall_win_y", b4.win_y, 0);
            check_eq("stall_rd_req", b4.rd_req, 0);
            check_eq("stall_shift_en", b4.shift_enable, 0);
        end
        cur = {b4.rd_x, b4.rd_y, b4.rd_orient, b4.shift_direction};
        if (b4.rd_req && b4.rd_ack) fq.push_back(cur);
        if (b4.shift_enable) n_shift++;
        if (b4.shift_enable != (b4.rd_req && b4.rd_ack)) se_viol++;
        if (pend && b4.rd_req && (cur != pend_val)) hold_viol++;
        pend = tb_rst_n && b4.rd_req && !b4.rd_ack;
        pend_val = cur;
        if (b4.win_valid && b4.win_ready) wq.push_back({b4.win_x, b4.win_y});
        if (b4.done) n_done++;
    end

    int n53_f = 0, n53_down = 0, n53_done = 0;
    logic [15:0] wq53 [$];

    always begin
        @(negedge tb_clk);
        b53.rd_ack = b53.rd_req;
        b53.win_ready = 1'b1;
        #1;
        if (b53.rd_req && b53.rd_ack) begin
            n53_f++;
            if (b53.shift_direction == 2'b11) n53_down++;
        end
        if (b53.win_valid) wq53.push_back({b53.win_x, b53.win_y});
        if (b53.done) n53_done++;
    end

    task automatic check_idle_outputs(input string pfx);
        check_eq({pfx, "_busy"}, b4.busy, 0);
        check_eq({pfx, "_done"}, b4.done, 0);
        check_eq({pfx, "_rd_req"}, b4.rd_req, 0);
        check_eq({pfx, "_rd_x"}, b4.rd_x, 0);
        check_eq({pfx, "_rd_y"}, b4.rd_y, 0);
        check_eq({pfx, "_rd_orient"}, b4.rd_orient, 0);
        check_eq({pfx, "_shift_en"}, b4.shift_enable, 0);
        check_eq({pfx, "_shift_dir"}, b4.shift_direction, 0);
        check_eq({pfx, "_win_valid"}, b4.win_valid, 0);
        check_eq({pfx, "_win_x"}, b4.win_x, 0);
        check_eq({pfx, "_win_y"}, b4.win_y, 0);
    endtask

    task automatic pulse_start4();
        @(negedge tb_clk); #2;
        b4.start = 1'b1;
        @(negedge tb_clk); #2;
        b4.start = 1'b0;
    endtask

    // Waits for the second 4x4 window, (1,0), to be presented
    task automatic wait_second_window(input string tag);
        bit found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge tb_clk); #2;
            if (b4.win_valid && b4.win_x == 8'd1 && b4.win_y == 8'd0) begin found = 1'b1; break; end
        end
        check_eq(tag, found, 1);
    endtask

    task automatic run_scan4(input string nm, input int ack_d, input int stall, input bit strayv,
                             input bit midstart);
        int fb, wb, d0, s0, h0, v0, st0;
        ack_delay = ack_d; stall_cfg = stall; stray = strayv;
        fb = fq.size(); wb = wq.size(); d0 = n_done; s0 = n_shift;
        h0 = hold_viol; v0 = se_viol; st0 = n_stall;
        pulse_start4();
        if (midstart) begin
            wait_second_window({nm, "_mid_wait"});
            b4.start = 1'b1;
            @(negedge tb_clk); #2;
            b4.start = 1'b0;
        end
        for (int i = 0; i < 400 && n_done == d0; i++) @(negedge tb_clk);
        repeat (4) @(negedge tb_clk);
        check_eq({nm, "_n_fetch"}, fq.size() - fb, 6);
        for (int i = 0; i < 6; i++)
            if (fb + i < fq.size()) check_eq($sformatf("%s_fetch%0d", nm, i), fq[fb + i], EXP_F4[i]);
        check_eq({nm, "_n_win"}, wq.size() - wb, 4);
        for (int i = 0; i < 4; i++)
            if (wb + i < wq.size()) check_eq($sformatf("%s_win%0d", nm, i), wq[wb + i], EXP_W4[i]);
        check_eq({nm, "_n_done"}, n_done - d0, 1);
        check_eq({nm, "_n_shift"}, n_shift - s0, 6);
        check_eq({nm, "_req_hold"}, hold_viol - h0, 0);
        check_eq({nm, "_shift_gate"}, se_viol - v0, 0);
        check_eq({nm, "_stall_cycles"}, n_stall - st0, stall);
        check_eq({nm, "_busy_after"}, b4.busy, 0);
    endtask

    initial begin
        int d0;
        b4.start = 1'b0;
        b53.start = 1'b0;
        #3;
        check_idle_outputs("reset");
        repeat (2) @(negedge tb_clk); #2;
        tb_rst_n = 1'b1;

        run_scan4("basic", 0, 0, 1'b0, 1'b0);
        run_scan4("ackdly", 3, 0, 1'b0, 1'b0);
        run_scan4("stall", 0, 5, 1'b0, 1'b0);
        run_scan4("stray", 0, 0, 1'b1, 1'b1);

        // Reset while the second window is on offer
        ack_delay = 0; stall_cfg = 0; stray = 1'b0;
        pulse_start4();
        wait_second_window("midrst_wait");
        d0 = n_done;
        #1 tb_rst_n = 1'b0;
        #1 check_idle_outputs("midrst");
        repeat (3) @(negedge tb_clk); #2;
        tb_rst_n = 1'b1;
        repeat (5) @(negedge tb_clk);
        check_eq("midrst_no_done", n_done - d0, 0);
        run_scan4("after_rst", 0, 0, 1'b0, 1'b0);

        // 5x3 image: a single row of three windows, never steps down
        @(negedge tb_clk); #2;
        b53.start = 1'b1;
        @(negedge tb_clk); #2;
        b53.start = 1'b0;
        for (int i = 0; i < 400 && n53_done == 0; i++) @(negedge tb_clk);
        repeat (4) @(negedge tb_clk);
        check_eq("w5h3_n_win", wq53.size(), 3);
        for (int i = 0; i < 3; i++)
            if (i < wq53.size()) check_eq($sformatf("w5h3_win%0d", i), wq53[i], EXP_W53[i]);
        check_eq("w5h3_n_fetch", n53_f, 5);
        check_eq("w5h3_no_down", n53_down, 0);
        check_eq("w5h3_n_done", n53_done, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
